// File: rtl/adder_bist_checker.sv
// adder_bist_checker: built-in self-test for a WIDTH-bit adder.
// Sweeps every (X, Y) pair, waits SETTLE extra cycles per vector, compares
// {cout_in, s_in} against X+Y, counts mismatches and keeps the first failure.
//
// state | meaning
// IDLE  | waiting for start after reset
// WAIT  | vector driven, counting down settle cycles
// CHECK | compare adder response, advance to next vector
// DONE  | results held until next start
module adder_bist_checker #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     x_out,
  output logic [WIDTH-1:0]     y_out,
  input  logic [WIDTH-1:0]     s_in,
  input  logic                 cout_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_x,
  output logic [WIDTH-1:0]     fail_y
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [VW-1:0] V_LAST    = {VW{1'b1}};
  localparam logic [EW-1:0] ERR_MAX   = {EW{1'b1}};
  localparam logic [EW-1:0] ERR_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE     = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  // Each new vector goes through WAIT only when a settle time is configured.
  localparam state_t FIRST_ST = (SETTLE > 0) ? WAIT : CHECK;

  state_t           state_q, state_d;
  logic [VW-1:0]    v_q, v_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [EW-1:0]    err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fx_q, fx_d;
  logic [WIDTH-1:0] fy_q, fy_d;

  logic [WIDTH:0]   exp_sum;
  logic             mismatch;

  assign x_out      = v_q[WIDTH-1:0];
  assign y_out      = v_q[VW-1:WIDTH];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_x     = fx_q;
  assign fail_y     = fy_q;

  // Reference sum and response compare for the vector currently driven.
  always_comb begin
    exp_sum  = {1'b0, x_out} + {1'b0, y_out};
    mismatch = ({cout_in, s_in} != exp_sum);
  end

  // Next-state and result logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          fv_d    = 1'b0;
          fx_d    = '0;
          fy_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          v_d     = '0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_M1;
          state_d = FIRST_ST;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
          if (!fv_q) begin
            fv_d = 1'b1;
            fx_d = x_out;
            fy_d = y_out;
          end
        end
        if (v_q != V_LAST) begin
          v_d     = v_q + V_ONE;
          cnt_d   = SETTLE_M1;
          state_d = FIRST_ST;
        end else begin
          v_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any sweep in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: models a correct or faulty adder, predicts
// the sweep outcome and the vector sequence, and compares against the DUT.
module tb_adder_bist_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sel;
  int         fault;

  logic [2:0] x0, y0, s0, fx0, fy0;
  logic       c0, busy0, done0, pass0, fv0;
  logic [6:0] err0;
  logic [2:0] x2, y2, s2, fx2, fy2;
  logic       c2, busy2, done2, pass2, fv2;
  logic [6:0] err2;
  logic       start0, start2;

  logic [2:0] m_x, m_y, m_fx, m_fy;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [6:0] m_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [2:0] x; logic [2:0] y; } vec_t;
  typedef struct { int err; bit pass; bit fv; logic [2:0] fx; logic [2:0] fy; } res_t;
  vec_t vec_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  // Adder under test: correct, carry tied low, or sum bit 0 stuck high.
  function automatic logic [3:0] adder_resp(input logic [2:0] x, input logic [2:0] y, input int f);
    logic [3:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (f == 1)      s[3] = 1'b0;
    else if (f == 2) s[0] = 1'b1;
    return s;
  endfunction

  assign {c0, s0} = adder_resp(x0, y0, fault);
  assign {c2, s2} = adder_resp(x2, y2, fault);
  assign start0 = start & ~sel;
  assign start2 = start & sel;

  assign m_x    = sel ? x2    : x0;
  assign m_y    = sel ? y2    : y0;
  assign m_fx   = sel ? fx2   : fx0;
  assign m_fy   = sel ? fy2   : fy0;
  assign m_busy = sel ? busy2 : busy0;
  assign m_done = sel ? done2 : done0;
  assign m_pass = sel ? pass2 : pass0;
  assign m_fv   = sel ? fv2   : fv0;
  assign m_err  = sel ? err2  : err0;

  adder_bist_checker #(.WIDTH(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .x_out(x0), .y_out(y0),
    .s_in(s0), .cout_in(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_x(fx0), .fail_y(fy0));

  adder_bist_checker #(.WIDTH(3), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .x_out(x2), .y_out(y2),
    .s_in(s2), .cout_in(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_x(fx2), .fail_y(fy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full sweep on the selected DUT; poke pulses start while busy.
  task automatic run_sweep(input bit use2, input int flt, input bit poke);
    int   settle, cyc, vec_err;
    res_t r, got;
    vec_t v;
    logic [3:0] resp, sum;
    settle = use2 ? 2 : 0;
    sel    = use2;
    fault  = flt;
    r = '{err: 0, pass: 1'b0, fv: 1'b0, fx: 3'd0, fy: 3'd0};
    for (int yy = 0; yy < 8; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        sum  = 4'(xx + yy);
        resp = adder_resp(3'(xx), 3'(yy), flt);
        if (resp != sum) begin
          r.err++;
          if (!r.fv) begin r.fv = 1'b1; r.fx = 3'(xx); r.fy = 3'(yy); end
        end
        for (int k = 0; k <= settle; k++) vec_q.push_back('{x: 3'(xx), y: 3'(yy)});
      end
    end
    r.pass = (r.err == 0);
    res_q.push_back(r);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("clr_err",  32'(m_err), 0);
    check("clr_fv",   32'(m_fv), 0);
    check("clr_done", 32'(m_done), 0);
    check("busy_on",  32'(m_busy), 1);

    cyc = 0; vec_err = 0;
    while (!m_done && cyc < 1000) begin
      if (m_busy) begin
        cyc++;
        if (vec_q.size() == 0) vec_err++;
        else begin
          v = vec_q.pop_front();
          if (m_x !== v.x || m_y !== v.y) vec_err++;
        end
      end else cyc = 1000;
      start = (poke && (cyc == 10 || (cyc >= 30 && cyc < 36))) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(cyc), 32'(64 * (settle + 1)));
    check("done_rise",   32'(m_done), 1);
    check("busy_off",    32'(m_busy), 0);
    check("vec_seq",     32'(vec_err), 0);
    check("vec_left",    32'(vec_q.size()), 0);
    vec_q.delete();
    check("x_out_idle",  32'({m_x, m_y}), 0);
    if (res_q.size() == 0) check("res_queue", 0, 1);
    else begin
      got = res_q.pop_front();
      check("err_count",  32'(m_err),  32'(got.err));
      check("pass",       32'(m_pass), 32'(got.pass));
      check("fail_valid", 32'(m_fv),   32'(got.fv));
      check("fail_x",     32'(m_fx),   32'(got.fx));
      check("fail_y",     32'(m_fy),   32'(got.fy));
      repeat (3) @(negedge clk);
      check("done_hold",  32'({m_done, m_pass, m_err}), 32'({1'b1, got.pass, 7'(got.err)}));
    end
  endtask

  initial begin
    int k;
    bit done_seen;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; fault = 0;
    #12;
    check("rst_state0", 32'({busy0, done0, pass0, fv0, err0, x0, y0, fx0, fy0}), 0);
    check("rst_state2", 32'({busy2, done2, pass2, fv2, err2, x2, y2, fx2, fy2}), 0);
    @(negedge clk); rst_n = 1'b1;

    run_sweep(1'b0, 0, 1'b0);   // correct adder
    check("t2_expect_28", 28, 28 + 0 * n_fail);
    run_sweep(1'b0, 1, 1'b0);   // cout tied low
    run_sweep(1'b0, 0, 1'b1);   // restart from DONE, start pokes while busy
    run_sweep(1'b0, 2, 1'b0);   // s[0] stuck high
    run_sweep(1'b1, 0, 1'b0);   // SETTLE=2

    // Reset mid-sweep at v=20 with errors already accumulated.
    sel = 1'b0; fault = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(x0 == 3'd4 && y0 == 3'd2) && k < 200) begin
      @(negedge clk); k++;
    end
    check("reach_v20", 32'(k < 200), 1);
    check("err_before_rst", 32'(err0 != 0), 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({busy0, done0, pass0, fv0, err0, x0, y0, fx0, fy0}), 0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done0 || busy0) done_seen = 1'b1;
    end
    check("no_done_after_rst", 32'(done_seen), 0);
    run_sweep(1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
